// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-serial adder.
`timescale 1ns/100ps
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } bs_state_t;

    localparam int BS_WIDTH_DEF = 8;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Start/busy/done handshake plus operand and result bus of the bit-serial adder.
`timescale 1ns/100ps
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/fulladder.sv
// Single-bit full adder cell.
`timescale 1ns/100ps
module fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic A,
    output logic cout
);
    assign A    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full adder plus a carry flop, LSB first, one bit per clock.
// Result and carry registers update only when the last bit has been processed.
`timescale 1ns/100ps
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH_DEF
) (
    input logic               clk,
    input logic               rst_n,
    bit_serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    bs_state_t        state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] acc_sr_r;
    logic             carry_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] acc_next_s;

    fulladder u_fa (
        .x    (a_sr_r[0]),
        .y    (b_sr_r[0]),
        .cin  (carry_r),
        .A    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign acc_next_s = {fa_sum_s, acc_sr_r[WIDTH-1:1]};

    // Control FSM with operand shifters, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_sr_r    <= '0;
            b_sr_r    <= '0;
            acc_sr_r  <= '0;
            carry_r   <= 1'b0;
            bit_cnt_r <= '0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr_r    <= bus.a;
                        b_sr_r    <= bus.b;
                        carry_r   <= bus.cin;
                        acc_sr_r  <= '0;
                        bit_cnt_r <= '0;
                        state_r   <= RUN;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                    end else begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b0;
                    end
                end
                RUN: begin
                    acc_sr_r  <= acc_next_s;
                    carry_r   <= fa_cout_s;
                    a_sr_r    <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r    <= {1'b0, b_sr_r[WIDTH-1:1]};
                    bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (bit_cnt_r == LAST_BIT) begin
                        sum_r   <= acc_next_s;
                        cout_r  <= fa_cout_s;
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial adder built around the team's existing `fulladder` cell: one full adder plus a carry flip-flop sums two WIDTH-bit operands, one bit per clock, LSB first. It sits directly downstream of `fulladder`, taking its `A`/`cout` outputs each cycle and accumulating them into a registered result. The trade-off against a ripple array is area for latency. A start/busy/done handshake lets a controller or bench launch operations back-to-back.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; high while in DONE.
- `sum`  out  WIDTH  result register.
- `cout`  out  1  final carry register.

## Operation
- Result: {`cout`,`sum`} = `a` + `b` + `cin`, exact. This fits in WIDTH+1 bits, so no overflow is possible.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → RUN while `bit_cnt` < WIDTH-1.
  - RUN → DONE on the edge that processes bit WIDTH-1.
  - DONE → RUN if `start`=1; otherwise DONE → IDLE.
- Accepting edge:
  - `a_sr`←`a`, `b_sr`←`b`, `carry`←`cin`.
  - `acc_sr` is cleared and `bit_cnt`←0.
- Each RUN edge:
  - The `fulladder` inputs are `x`=`a_sr[0]`, `y`=`b_sr[0]`, `cin`=`carry`.
  - `acc_sr` shifts right with `A` entering at the MSB.
  - `carry`←`cout`.
  - `a_sr` and `b_sr` shift right.
  - `bit_cnt` increments.
- On the RUN→DONE edge, `sum` is loaded with the final shifted `acc_sr` value (including the last `A`) and `cout` is loaded with the last full-adder `cout`.
- `sum` and `cout` change only on that edge. They hold their values through later RUN periods until the next completion.
- `start`, `a`, `b` and `cin` are ignored while in RUN; the operands in flight are unaffected.
- `bit_cnt` width is $clog2(WIDTH); it must not wrap before WIDTH-1 is reached.

## Timing
- Reset (async assert, synchronous deassert handled upstream): state=IDLE and every register is 0, so `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Accepting edge E:
  - `busy`=1 from E to E+WIDTH.
  - DONE is entered at edge E+WIDTH, so `done`=1 and a valid `sum`/`cout` are visible in the cycle after E+WIDTH.
  - `done` falls at E+WIDTH+1.
- Latency is WIDTH+1 edges from accept to the `done` pulse ending.
- Peak throughput is one operation per WIDTH+1 cycles, achieved with `start` held high: the accept in DONE gives `busy` 0→1 with no IDLE gap.
- Reset asserted mid-RUN aborts immediately:
  - no `done` pulse;
  - `sum` and `cout` are forced to 0;
  - the next `start` after deassertion behaves as a fresh accept.

## Structure
- Shared package `bit_serial_pkg` holds:
  - the state typedef `bs_state_t` (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - default width constant `BS_WIDTH_DEF`=8.
- One sub-module: an instance of the existing `fulladder` (ports `x`, `y`, `cin`, `A`, `cout`). No other hierarchy.
- Timescale is 1ns/100ps.

## Test plan
All scenarios use WIDTH=8.
1. `a`=00, `b`=00, `cin`=0, start pulsed → `busy` high for 8 cycles, then a `done` pulse; `sum`=00, `cout`=0.
2. `a`=FF, `b`=01, `cin`=0 → `sum`=00, `cout`=1; `done` at accept+8.
3. `a`=A5, `b`=5A, `cin`=1 → `sum`=00, `cout`=1 (full carry ripple through all bits).
4. `start` held high, with `a`=3C, `b`=0F followed by `a`=80, `b`=80:
   - first `done`: `sum`=4B, `cout`=0;
   - second `done` exactly 9 cycles later: `sum`=00, `cout`=1;
   - no IDLE cycle between the two operations.
5. `a`=12, `b`=34; `a`/`b`/`start` toggled to FF during RUN → result `sum`=46, `cout`=0; only one `done` pulse.
6. `rst_n` dropped at accept+4 → `busy`, `done`, `sum`, `cout` all 0 at once, and no `done` follows. After deassertion, `a`=01, `b`=01 → `sum`=02.
